rf_write_arbiter: RTL
=====================

// Module: rf_write_arbiter
// PURPOSE
//  Upstream write stage for the 4-write-port CGRA register file (8 regs x 32b default).
//  Collects write requests from up to NUM_REQ producers (FUs, routing outputs) over valid/ready.
//  Grants up to 4 per cycle with rotating round-robin priority.
//  Drives registered WE/address/data onto the register file write ports.
//  Guarantees no two ports carry the same address in one cycle, so register-file port priority never matters.
// PARAMETERS
//  NUM_REQ   8   number of requesters; power of 2, range 4..16
//  log2regs  3   register address width (register file depth = 2**log2regs)
//  size      32  data width
// PORTS
//  CGRA_Clock   in   1                 single clock, all state on rising edge
//  CGRA_Reset   in   1                 reset, asynchronous, active-low
//  req_valid    in   NUM_REQ           request i pending
//  req_addr     in   NUM_REQ*log2regs  request i address, slice [i*log2regs +: log2regs]
//  req_data     in   NUM_REQ*size      request i data, slice [i*size +: size]
//  req_ready    out  NUM_REQ           request i accepted this cycle (combinational)
//  WE0..WE3     out  1 each            registered write enables to register file ports 0..3
//  address_in0..address_in3  out  log2regs each  registered write addresses
//  in0..in3     out  size each         registered write data
// BEHAVIOUR
//  Reset (CGRA_Reset=0) forces, asynchronously:
//   - WEk=0, address_ink=0, ink=0, rr_ptr=0
//   - req_ready=0 while reset is held
//  Grant scan (combinational), order i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   Request i is granted iff all hold:
//   - req_valid[i]=1
//   - fewer than 4 grants so far this cycle
//   - req_addr[i] differs from every address already granted this cycle
//  req_ready[i] = grant[i]; transfer = valid & ready.
//  Port assignment: k-th grant in scan order goes to port k.
//   Next edge: WEk=1, address_ink/ink = that request. Unused ports: WEk=0, address_ink=0, ink=0.
//  Latency: transfer at edge N -> WE visible after edge N; register file commits at edge N+1.
//  rr_ptr: if any grant, rr_ptr <= (index of last grant + 1) mod NUM_REQ; else hold.
//   Pointer width $clog2(NUM_REQ); wrap-around is natural modulo.
//  Fairness: a continuously valid request is granted within NUM_REQ cycles,
//   including the all-same-address case.
//  Producer rules: req_valid must not depend on req_ready.
//   Once valid, addr/data stay stable until transfer. A dropped valid is legal and is simply not granted.
//  No read bypass / RAW forwarding: a reader sees new data 2 edges after transfer.
//  Reset mid-operation: registered writes in flight are discarded.
//   Ungranted requests are not accepted. After release, scan restarts at req0.
// STRUCTURE
//  Package cgra_rf_pkg:
//   - RF_LOG2REGS=3, RF_SIZE=32, RF_NUM_WP=4
//   - typedef rf_wr_req_t {addr, data}
//   - typedef rf_wr_port_t {we, addr, data}
//  Sub-module rf_wr_grant_scan (pure combinational):
//   - inputs: valid, addr, rr_ptr
//   - outputs: grant vector, per-port request index/valid, next rr_ptr
//  Top holds rr_ptr and the 4 output port registers.
// TESTING
//  1 Reset held low, all req_valid=1 -> req_ready=0; WE0..3=0, address_in*=0, in*=0.
//  2 rr_ptr=0; req0..7 valid, addr=i, data=0xA0+i ->
//     ready=0x0F; next cycle WE0..3=1, addr 0..3, data 0xA0..0xA3; rr_ptr=4;
//     then ready=0xF0, ports carry addr 4..7.
//  3 req0 addr5 data 0x11, req1 addr5 data 0x22 -> ready=0x01; WE0=1 addr5 0x11, WE1=0;
//     next cycle ready=0x02, port0 data 0x22.
//  4 Only req6 valid (rr_ptr=0) -> granted, port0, rr_ptr=7;
//     then only req1 valid -> granted via wrap, rr_ptr=2.
//  5 All 8 valid, all addr=3 -> one grant per cycle in order 0..7 over 8 cycles;
//     only WE0 ever asserted; ungranted addr/data held stable.
//  6 CGRA_Reset pulsed low between edges mid-stream -> WE0..3 drop immediately;
//     after release first grant is req0, port0.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the CGRA register-file write path.
// Default widths and the write-port bundle.
package cgra_rf_pkg;

  localparam int RF_LOG2REGS = 3;
  localparam int RF_SIZE     = 32;
  localparam int RF_NUM_WP   = 4;

  typedef struct packed {
    logic [RF_LOG2REGS-1:0] addr;
    logic [RF_SIZE-1:0]     data;
  } rf_wr_req_t;

  typedef struct packed {
    logic                   we;
    logic [RF_LOG2REGS-1:0] addr;
    logic [RF_SIZE-1:0]     data;
  } rf_wr_port_t;

  function automatic int unsigned ptr_w(
    input int unsigned n
  );
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Write-request bundle between producers and the arbiter.
// Flat vectors, request i in slice i.
interface rf_write_arbiter_if #(
  parameter int NUM_REQ  = 8,
  parameter int log2regs = 3,
  parameter int size     = 32
);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*log2regs-1:0] req_addr;
  logic [NUM_REQ*size-1:0]     req_data;
  logic [NUM_REQ-1:0]          req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rf_write_arbiter_grant_scan.sv
// Round-robin scan granting up to four requests per cycle.
// Granted addresses are kept pairwise distinct.
module rf_wr_grant_scan
  import cgra_rf_pkg::*;
#(
  parameter int NUM_REQ  = 8,
  parameter int log2regs = 3,
  parameter int PW       = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]          valid_i,
  input  logic [NUM_REQ*log2regs-1:0] addr_i,
  input  logic [PW-1:0]               rr_ptr_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic [RF_NUM_WP-1:0][PW-1:0] port_idx_o,
  output logic [RF_NUM_WP-1:0]        port_vld_o,
  output logic [PW-1:0]               rr_ptr_nxt_o
);

  logic [RF_NUM_WP-1:0][log2regs-1:0] paddr;
  logic [RF_NUM_WP-1:0][PW-1:0]       pidx;
  logic [RF_NUM_WP-1:0]               pvld;
  logic [NUM_REQ-1:0]                 gnt;
  logic [PW-1:0]                      nxt;
  logic [PW-1:0]                      idx;
  logic [log2regs-1:0]                a;
  logic [2:0]                         cnt;
  logic                               hit;

  // Walk requests from rr_ptr; k-th grant lands on port k.
  always_comb begin
    paddr = '0;
    pidx  = '0;
    pvld  = '0;
    gnt   = '0;
    nxt   = rr_ptr_i;
    idx   = '0;
    a     = '0;
    cnt   = '0;
    hit   = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = rr_ptr_i + PW'(j);
      a   = addr_i[idx*log2regs +: log2regs];
      hit = 1'b0;
      for (int k = 0; k < RF_NUM_WP; k++) begin
        if (pvld[k] && paddr[k] == a) hit = 1'b1;
      end
      if (valid_i[idx] && !cnt[2] && !hit) begin
        gnt[idx]          = 1'b1;
        pidx[cnt[1:0]]    = idx;
        pvld[cnt[1:0]]    = 1'b1;
        paddr[cnt[1:0]]   = a;
        cnt               = cnt + 3'd1;
        nxt               = idx + PW'(1);
      end
    end
  end

  assign grant_o      = gnt;
  assign port_idx_o   = pidx;
  assign port_vld_o   = pvld;
  assign rr_ptr_nxt_o = nxt;

endmodule

// File: rtl/rf_write_arbiter.sv
// Write arbiter in front of the 4-write-port CGRA register file.
// Holds the rotating pointer and registered write ports.
module rf_write_arbiter
  import cgra_rf_pkg::*;
#(
  parameter int NUM_REQ  = 8,
  parameter int log2regs = 3,
  parameter int size     = 32
) (
  input  logic                CGRA_Clock,
  input  logic                CGRA_Reset,
  rf_write_arbiter_if.slave   req,
  output logic                WE0,
  output logic                WE1,
  output logic                WE2,
  output logic                WE3,
  output logic [log2regs-1:0] address_in0,
  output logic [log2regs-1:0] address_in1,
  output logic [log2regs-1:0] address_in2,
  output logic [log2regs-1:0] address_in3,
  output logic [size-1:0]     in0,
  output logic [size-1:0]     in1,
  output logic [size-1:0]     in2,
  output logic [size-1:0]     in3
);

  localparam int PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           grant;
  logic [RF_NUM_WP-1:0][PW-1:0] pidx;
  logic [RF_NUM_WP-1:0]         pvld;
  logic [PW-1:0]                rr_nxt;

  logic [PW-1:0]                        rr_ptr_q;
  logic [RF_NUM_WP-1:0]                 we_q, we_d;
  logic [RF_NUM_WP-1:0][log2regs-1:0]   addr_q, addr_d;
  logic [RF_NUM_WP-1:0][size-1:0]       data_q, data_d;

  rf_wr_grant_scan #(
    .NUM_REQ  (NUM_REQ),
    .log2regs (log2regs),
    .PW       (PW)
  ) u_scan (
    .valid_i      (req.req_valid),
    .addr_i       (req.req_addr),
    .rr_ptr_i     (rr_ptr_q),
    .grant_o      (grant),
    .port_idx_o   (pidx),
    .port_vld_o   (pvld),
    .rr_ptr_nxt_o (rr_nxt)
  );

  // Nothing is accepted while reset is held.
  assign req.req_ready = grant & {NUM_REQ{CGRA_Reset}};

  // Route each granted request onto its port; idle ports go to zero.
  always_comb begin
    we_d   = '0;
    addr_d = '0;
    data_d = '0;
    for (int k = 0; k < RF_NUM_WP; k++) begin
      if (pvld[k]) begin
        we_d[k]   = 1'b1;
        addr_d[k] = req.req_addr[pidx[k]*log2regs +: log2regs];
        data_d[k] = req.req_data[pidx[k]*size +: size];
      end
    end
  end

  // Pointer and write-port registers; reset drops in-flight writes.
  always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
    if (!CGRA_Reset) begin
      rr_ptr_q <= '0;
      we_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      if (|grant) rr_ptr_q <= rr_nxt;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign WE0 = we_q[0];
  assign WE1 = we_q[1];
  assign WE2 = we_q[2];
  assign WE3 = we_q[3];
  assign address_in0 = addr_q[0];
  assign address_in1 = addr_q[1];
  assign address_in2 = addr_q[2];
  assign address_in3 = addr_q[3];
  assign in0 = data_q[0];
  assign in1 = data_q[1];
  assign in2 = data_q[2];
  assign in3 = data_q[3];

endmodule
